// File: rtl/reg_dump_unit_pkg.sv
// Shared definitions for the register dump path: byte width, bytes per
// register word and the dump FSM state encoding. The MIPS core and the
// debug unit use the same constants so that the UART byte stream framing agrees.
package reg_dump_unit_pkg;

  localparam int NB_BYTE       = 8;
  localparam int LEN_DEFAULT   = 32;
  localparam int BYTES_PER_REG = LEN_DEFAULT / NB_BYTE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4,
    ST_DONE = 3'd5
  } dump_state_t;

  // Number of bytes in one word of len bits.
  function automatic int bytes_per_word(input int len, input int nb);
    return len / nb;
  endfunction

endpackage

// File: rtl/reg_dump_serializer.sv
// Purpose: word shift register, byte-in-word counter and optional running XOR checksum.
// Latency: a loaded word shows its MS byte on top_byte the next cycle; shift/accum act in one cycle.
// Backpressure: none; the owning FSM decides when to load, shift and accumulate.
// Ports: clk/rst (sync, active-high); clear = dump start; load_word/word = capture bank data;
//        shift = advance to the next byte; accum/acc_byte = fold a sent byte into the checksum;
//        top_byte = current MS byte; last_byte = top_byte is the word's final byte; checksum.
// Optional: REG_DUMP_CHECKSUM_EN enables the checksum register (otherwise checksum reads 0).
module reg_dump_serializer #(
  parameter int LEN     = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load_word,
  input  logic [LEN-1:0]     word,
  input  logic               shift,
  input  logic               accum,
  input  logic [NB_BYTE-1:0] acc_byte,
  output logic [NB_BYTE-1:0] top_byte,
  output logic               last_byte,
  output logic [NB_BYTE-1:0] checksum
);
  import reg_dump_unit_pkg::*;

  localparam int BPW = bytes_per_word(LEN, NB_BYTE);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [LEN-1:0] shreg;
  logic [CW-1:0]  byte_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (load_word) begin
      shreg    <= word;
      byte_cnt <= '0;
    end else if (shift) begin
      shreg    <= shreg << NB_BYTE;
      byte_cnt <= byte_cnt + CW'(1);
    end
  end

  assign top_byte  = shreg[LEN-1 -: NB_BYTE];
  assign last_byte = (byte_cnt == CW'(BPW - 1));

`ifdef REG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] csum;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      csum <= '0;
    end else if (accum) begin
      csum <= csum ^ acc_byte;
    end
  end

  assign checksum = csum;
`else
  logic unused_acc;
  assign unused_acc = accum ^ (^acc_byte) ^ clear;
  assign checksum   = '0;
`endif

endmodule

// File: rtl/reg_dump_unit.sv
// Purpose: dumps every register of the MIPS bank, MS byte first, into the UART TX byte stream.
// Latency: READ_LAT+1 cycles per bank read, then LOAD/SEND/WAIT per byte; 3-cycle minimum start-to-start.
// Backpressure: each byte waits in WAIT until the UART returns i_tx_done; i_start is ignored while busy.
// Ports: i_clk/i_rst (sync, active-high); i_start begins a dump; o_reg_addr/i_reg_data = bank read port;
//        o_tx_data/o_tx_start/i_tx_done = UART TX handshake; o_busy = dump in progress; o_done = end pulse.
// Optional: REG_DUMP_CHECKSUM_EN appends one XOR-of-all-bytes byte after the last register.
module reg_dump_unit #(
  parameter int LEN                  = 32,
  parameter int CANTIDAD_REGISTROS   = 32,
  parameter int NB_ADDRESS_REGISTROS = $clog2(CANTIDAD_REGISTROS),
  parameter int NB_BYTE              = 8,
  parameter int READ_LAT             = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic [LEN-1:0]                  i_reg_data,
  input  logic                            i_tx_done,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_reg_addr,
  output logic [NB_BYTE-1:0]              o_tx_data,
  output logic                            o_tx_start,
  output logic                            o_busy,
  output logic                            o_done
);
  import reg_dump_unit_pkg::*;

  localparam int LAT_W = $clog2(READ_LAT + 1);
  localparam logic [NB_ADDRESS_REGISTROS-1:0] LAST_ADDR =
    NB_ADDRESS_REGISTROS'(CANTIDAD_REGISTROS - 1);

  dump_state_t        state;
  logic [LAT_W-1:0]   lat_cnt;
  logic               start_acc;
  logic               done_acc;
  logic               load_word;
  logic               shift;
  logic               accum;
  logic               in_csum;
  logic [NB_BYTE-1:0] top_byte;
  logic               last_byte;
  logic [NB_BYTE-1:0] checksum;

`ifdef REG_DUMP_CHECKSUM_EN
  // Set once the register bytes are exhausted; the next LOAD sends the checksum.
  logic csum_phase;
  assign in_csum = csum_phase;
`else
  logic unused_checksum;
  assign unused_checksum = ^checksum;
  assign in_csum         = 1'b0;
`endif

  assign start_acc = (state == ST_IDLE) && i_start;
  assign done_acc  = (state == ST_WAIT) && i_tx_done;
  // The address has been stable for READ_LAT cycles when lat_cnt reaches READ_LAT.
  assign load_word = (state == ST_READ) && (lat_cnt == LAT_W'(READ_LAT));
  assign shift     = done_acc && !last_byte && !in_csum;
  assign accum     = done_acc && !in_csum;

  reg_dump_serializer #(
    .LEN     (LEN),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .clk       (i_clk),
    .rst       (i_rst),
    .clear     (start_acc),
    .load_word (load_word),
    .word      (i_reg_data),
    .shift     (shift),
    .accum     (accum),
    .acc_byte  (o_tx_data),
    .top_byte  (top_byte),
    .last_byte (last_byte),
    .checksum  (checksum)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      o_reg_addr <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_phase <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_reg_addr <= '0;
            lat_cnt    <= '0;
            o_busy     <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_phase <= 1'b0;
`endif
            state      <= ST_READ;
          end
        end

        ST_READ: begin
          if (lat_cnt == LAT_W'(READ_LAT)) begin
            state <= ST_LOAD;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        // o_tx_data and o_tx_start are registered together so the byte is
        // valid in the same cycle as the start pulse (the SEND cycle).
        ST_LOAD: begin
`ifdef REG_DUMP_CHECKSUM_EN
          o_tx_data <= csum_phase ? checksum : top_byte;
`else
          o_tx_data <= top_byte;
`endif
          o_tx_start <= 1'b1;
          state      <= ST_SEND;
        end

        ST_SEND: begin
          o_tx_start <= 1'b0;
          state      <= ST_WAIT;
        end

        ST_WAIT: begin
          if (i_tx_done) begin
            if (in_csum) begin
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else if (!last_byte) begin
              state <= ST_LOAD;
            end else if (o_reg_addr != LAST_ADDR) begin
              o_reg_addr <= o_reg_addr + NB_ADDRESS_REGISTROS'(1);
              lat_cnt    <= '0;
              state      <= ST_READ;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              csum_phase <= 1'b1;
              state      <= ST_LOAD;
`else
              o_done <= 1'b1;
              state  <= ST_DONE;
`endif
            end
          end
        end

        ST_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Bench for reg_dump_unit: instance A (READ_LAT=1, reg k = k) and instance B
// (READ_LAT=2 with a two-stage bank, reg k = 0x11111111*k). A UART model answers
// each o_tx_start with i_tx_done after tx_dly cycles.
module tb_reg_dump_unit;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int TOTAL = 129;
  localparam bit CSUM  = 1'b1;
`else
  localparam int TOTAL = 128;
  localparam bit CSUM  = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b, force_done;
  int   tx_dly;

  logic [31:0] rd_a, rd_b, stage_b;
  logic        done_m_a, done_m_b, tx_done_a, tx_done_b;
  logic [4:0]  addr_a, addr_b;
  logic [7:0]  txd_a, txd_b;
  logic        txs_a, txs_b, busy_a, busy_b, dn_a, dn_b;

  int errors = 0;
  int checks = 0;

  reg_dump_unit #(.LEN(32), .CANTIDAD_REGISTROS(32), .NB_ADDRESS_REGISTROS(5),
                  .NB_BYTE(8), .READ_LAT(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_reg_data(rd_a),
    .i_tx_done(tx_done_a), .o_reg_addr(addr_a), .o_tx_data(txd_a),
    .o_tx_start(txs_a), .o_busy(busy_a), .o_done(dn_a));

  reg_dump_unit #(.LEN(32), .CANTIDAD_REGISTROS(32), .NB_ADDRESS_REGISTROS(5),
                  .NB_BYTE(8), .READ_LAT(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_reg_data(rd_b),
    .i_tx_done(tx_done_b), .o_reg_addr(addr_b), .o_tx_data(txd_b),
    .o_tx_start(txs_b), .o_busy(busy_b), .o_done(dn_b));

  function automatic logic [31:0] bank_val(input logic [4:0] k);
    if (CSUM && k == 5'd31) return 32'hA5A5A5A5;
    return {27'd0, k};
  endfunction

  // Bank models: 1-cycle and 2-cycle registered reads.
  always @(posedge clk) rd_a <= bank_val(addr_a);
  always @(posedge clk) begin
    stage_b <= 32'h11111111 * {27'd0, addr_b};
    rd_b    <= stage_b;
  end

  // UART TX models.
  int cnt_a, cnt_b;
  always @(posedge clk) begin
    done_m_a <= 1'b0;
    if (rst) cnt_a <= 0;
    else if (txs_a) begin
      if (tx_dly <= 1) done_m_a <= 1'b1; else cnt_a <= tx_dly - 1;
    end else if (cnt_a > 0) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) done_m_a <= 1'b1;
    end
  end
  always @(posedge clk) begin
    done_m_b <= 1'b0;
    if (rst) cnt_b <= 0;
    else if (txs_b) begin
      if (tx_dly <= 1) done_m_b <= 1'b1; else cnt_b <= tx_dly - 1;
    end else if (cnt_b > 0) begin
      cnt_b <= cnt_b - 1;
      if (cnt_b == 1) done_m_b <= 1'b1;
    end
  end
  assign tx_done_a = done_m_a | force_done;
  assign tx_done_b = done_m_b;

  // Monitor: stats restart whenever a start pulse lands on an idle instance.
  logic [7:0] bytes_a[$];
  logic [7:0] bytes_b[$];
  int cyc = 0, last_a = 0, gap_min = 1000, gap_max = 0, gap3 = 0;
  int dones_a = 0, dones_b = 0;
  bit busy_low = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (start_a && !busy_a) begin
      bytes_a.delete(); dones_a = 0; gap_min = 1000; gap_max = 0; gap3 = 0; busy_low = 1'b0;
    end
    if (start_b && !busy_b) begin
      bytes_b.delete(); dones_b = 0;
    end
    if (txs_a) begin
      if (bytes_a.size() > 0) begin
        if (cyc - last_a < gap_min) gap_min = cyc - last_a;
        if (cyc - last_a > gap_max) gap_max = cyc - last_a;
        if (cyc - last_a == 3) gap3++;
      end
      last_a = cyc;
      bytes_a.push_back(txd_a);
    end
    if (bytes_a.size() > 0 && dones_a == 0 && !busy_a) busy_low = 1'b1;
    if (dn_a) dones_a++;
    if (txs_b) bytes_b.push_back(txd_b);
    if (dn_b) dones_b++;
  end

  typedef struct {
    bit         sel;
    int         pos;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_table(input bit sel, input string tag);
    logic [7:0] act;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].sel == sel) begin
        if (sel) act = (tbl[i].pos < bytes_b.size()) ? bytes_b[tbl[i].pos] : 8'hxx;
        else     act = (tbl[i].pos < bytes_a.size()) ? bytes_a[tbl[i].pos] : 8'hxx;
        check($sformatf("%s byte[%0d]", tag, tbl[i].pos), {24'd0, act}, {24'd0, tbl[i].exp});
      end
    end
  endtask

  task automatic pulse(input bit sel);
    @(posedge clk); #1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_dn(input bit sel, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ((sel ? dones_b : dones_a) > 0) begin seen = 1'b1; break; end
    end
    check({tag, " done seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_bytes(input int n, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bytes_a.size() >= n) begin seen = 1'b1; break; end
    end
    check({tag, " reached bytes"}, {31'd0, seen}, 32'd1);
  endtask

  int n_hold;

  initial begin
    tbl.push_back('{1'b0, 0,   8'h00});
    tbl.push_back('{1'b0, 3,   8'h00});
    tbl.push_back('{1'b0, 20,  8'h00});
    tbl.push_back('{1'b0, 22,  8'h00});
    tbl.push_back('{1'b0, 23,  8'h05});
    tbl.push_back('{1'b0, 123, 8'h1E});
    tbl.push_back('{1'b0, 127, CSUM ? 8'hA5 : 8'h1F});
    if (CSUM) tbl.push_back('{1'b0, 128, 8'h1F});
    tbl.push_back('{1'b1, 3,   8'h00});
    tbl.push_back('{1'b1, 12,  8'h33});
    tbl.push_back('{1'b1, 13,  8'h33});
    tbl.push_back('{1'b1, 15,  8'h33});
    tbl.push_back('{1'b1, 60,  8'hFF});
    tbl.push_back('{1'b1, 63,  8'hFF});

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; force_done = 1'b0; tx_dly = 10;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst addr",  {27'd0, addr_a}, 32'd0);
    check("rst data",  {24'd0, txd_a},  32'd0);
    check("rst start", {31'd0, txs_a},  32'd0);
    check("rst busy",  {31'd0, busy_a}, 32'd0);
    check("rst done",  {31'd0, dn_a},   32'd0);

    // Full dump, slow UART.
    pulse(1'b0);
    wait_dn(1'b0, "slow");
    check("slow count", bytes_a.size(), TOTAL);
    apply_table(1'b0, "slow");
    check("slow busy held", {31'd0, busy_low}, 32'd0);
    @(negedge clk);
    check("slow busy drop", {31'd0, busy_a}, 32'd0);
    check("slow done 1cyc", {31'd0, dn_a},   32'd0);
    check("slow addr hold", {27'd0, addr_a}, 32'd31);
    repeat (5) @(negedge clk);
    check("slow done pulses", dones_a, 1);

    // Fast UART: minimum byte spacing.
    tx_dly = 1;
    pulse(1'b0);
    wait_dn(1'b0, "fast");
    check("fast count", bytes_a.size(), TOTAL);
    check("fast gap min", gap_min, 3);
    check("fast gap max", gap_max, 5);
    check("fast gap3 count", gap3, CSUM ? 97 : 96);
    check("fast busy held", {31'd0, busy_low}, 32'd0);

    // Start while busy is ignored.
    tx_dly = 10;
    pulse(1'b0);
    wait_bytes(40, "restart");
    pulse(1'b0);
    wait_dn(1'b0, "restart");
    check("restart count", bytes_a.size(), TOTAL);
    apply_table(1'b0, "restart");
    repeat (3) @(negedge clk);
    check("restart done pulses", dones_a, 1);

    // Reset mid-dump with a coincident tx_done.
    pulse(1'b0);
    wait_bytes(50, "abort");
    @(posedge clk); #1;
    rst = 1'b1; force_done = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; force_done = 1'b0;
    @(negedge clk);
    check("abort addr",  {27'd0, addr_a}, 32'd0);
    check("abort data",  {24'd0, txd_a},  32'd0);
    check("abort start", {31'd0, txs_a},  32'd0);
    check("abort busy",  {31'd0, busy_a}, 32'd0);
    check("abort done",  {31'd0, dn_a},   32'd0);
    n_hold = bytes_a.size();
    repeat (30) @(negedge clk);
    check("abort no tx", bytes_a.size(), n_hold);
    check("abort idle busy", {31'd0, busy_a}, 32'd0);
    pulse(1'b0);
    wait_dn(1'b0, "after abort");
    check("after abort count", bytes_a.size(), TOTAL);
    apply_table(1'b0, "after abort");

    // Two-cycle bank latency.
    tx_dly = 1;
    pulse(1'b1);
    wait_dn(1'b1, "lat2");
    check("lat2 count", bytes_b.size(), TOTAL);
    apply_table(1'b1, "lat2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
